gf2_poly_div_24bit: RTL and testbench



---
 rtl/gf2_poly_div_24bit_pkg.sv | 25 ++
 rtl/gf2_poly_div_24bit_deg_enc.sv | 32 +++
 rtl/gf2_poly_div_24bit.sv | 145 ++++++++++++++
 tb/tb_gf2_poly_div_24bit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gf2_poly_div_24bit_pkg.sv
// ---------------------------------------------------------------------------
// gf2_pkg
// Shared constants and types for the GF(2)[x] division/inversion family.
//   N_DEF  : default divisor width (matches the OKA_24bit multiplier operand)
//   DVD_W  : dividend / quotient width, 2N-1 (an OKA product)
//   REM_W  : remainder width, N-1
//   PTR_W  : width of the bit pointer that walks the dividend
//   DEG_W  : width of a divisor degree value
//   gf2_state_t : IDLE / RUN / DONE controller state
// ---------------------------------------------------------------------------
package gf2_pkg;

    localparam int N_DEF = 24;
    localparam int DVD_W = 2 * N_DEF - 1;
    localparam int REM_W = N_DEF - 1;
    localparam int PTR_W = $clog2(DVD_W);
    localparam int DEG_W = $clog2(N_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gf2_state_t;

endpackage

// File: rtl/gf2_poly_div_24bit_deg_enc.sv
// ---------------------------------------------------------------------------
// gf2_deg_enc
// Leading-one detector: reports the degree of a GF(2) polynomial.
//   i_poly : W-bit polynomial, bit i = coefficient of x^i
//   o_deg  : index of the highest set bit (0 when i_poly == 0)
//   o_zero : 1 when i_poly is the zero polynomial
// Purely combinational; also intended for the inverse/GCD blocks.
// ---------------------------------------------------------------------------
module gf2_deg_enc
    import gf2_pkg::*;
#(
    parameter int W     = N_DEF,
    parameter int DEG_W = $clog2(W)
) (
    input  logic [W-1:0]     i_poly,
    output logic [DEG_W-1:0] o_deg,
    output logic             o_zero
);

    // Ascending scan: the last hit is the highest set bit.
    always_comb begin
        o_deg = '0;
        for (int i = 0; i < W; i++) begin
            if (i_poly[i]) begin
                o_deg = DEG_W'(i);
            end
        end
    end

    assign o_zero = ~|i_poly;

endmodule

// File: rtl/gf2_poly_div_24bit.sv
// ---------------------------------------------------------------------------
// gf2_poly_div_24bit
// Bit-serial carry-less (GF(2)[x]) long divider. Inverse of the OKA
// carry-less multipliers: dividend (2N-1 bits) / divisor (N bits).
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : request valid (producer holds it until in_ready)
//   in_ready     : divider idle and able to accept a request
//   dividend     : 2N-1 bit dividend, bit i = coeff of x^i
//   divisor      : N bit divisor
//   out_valid    : result valid, held until out_ready
//   out_ready    : consumer accepts the result
//   quotient     : 2N-1 bit carry-less quotient
//   remainder    : N-1 bit carry-less remainder, deg < deg(divisor)
//   div_by_zero  : divisor was zero (qualified by out_valid)
//
// Operation: the divisor is left-aligned under the top dividend bit, then
// one quotient bit is produced per cycle while the aligned divisor slides
// right. RUN takes 2N-1-deg(divisor) cycles; a zero divisor skips RUN.
// ---------------------------------------------------------------------------
module gf2_poly_div_24bit
    import gf2_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-2:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] quotient,
    output logic [N-2:0]   remainder,
    output logic           div_by_zero
);

    localparam int DW = 2 * N - 1;
    localparam int RW = N - 1;
    localparam int PW = $clog2(DW);
    localparam int GW = $clog2(N);

    gf2_state_t      r_state;
    logic [DW-1:0]   r_w;      // working dividend / partial remainder
    logic [DW-1:0]   r_d;      // aligned divisor
    logic [DW-1:0]   r_q;      // quotient shift register
    logic [PW-1:0]   r_p;      // dividend bit currently being cleared
    logic [GW-1:0]   r_deg;    // degree of the captured divisor

    logic [GW-1:0]   w_deg;
    logic            w_zero;
    logic            w_accept;
    logic [DW-1:0]   w_d_init;
    logic            w_bit;
    logic [DW-1:0]   w_w_next;
    logic [DW-1:0]   w_q_next;
    logic            w_last;

    gf2_deg_enc #(
        .W     (N),
        .DEG_W (GW)
    ) u_deg_enc (
        .i_poly (divisor),
        .o_deg  (w_deg),
        .o_zero (w_zero)
    );

    assign in_ready = (r_state == IDLE) && !rst;
    assign w_accept = in_valid && in_ready;

    // Shift the divisor so its leading one sits on the top dividend bit.
    assign w_d_init = DW'(divisor) << (PW'(DW - 1) - PW'(w_deg));

    // One long-division step: the bit under the divisor's leading one
    // becomes the next quotient bit and, if set, is cancelled by XOR.
    assign w_bit    = r_w[r_p];
    assign w_w_next = w_bit ? (r_w ^ r_d) : r_w;
    assign w_q_next = {r_q[DW-2:0], w_bit};
    assign w_last   = (r_p == PW'(r_deg));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_w         <= '0;
            r_d         <= '0;
            r_q         <= '0;
            r_p         <= '0;
            r_deg       <= '0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_w         <= dividend;
                        r_d         <= w_d_init;
                        r_p         <= PW'(DW - 1);
                        r_q         <= '0;
                        r_deg       <= w_deg;
                        div_by_zero <= w_zero;
                        if (w_zero) begin
                            quotient  <= '0;
                            remainder <= '0;
                            out_valid <= 1'b1;
                            r_state   <= DONE;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end

                RUN: begin
                    r_q <= w_q_next;
                    r_w <= w_w_next;
                    r_d <= r_d >> 1;
                    r_p <= r_p - PW'(1);
                    if (w_last) begin
                        // Every bit at or above deg(divisor) has been cancelled.
                        assert ((w_w_next >> r_deg) == '0);
                        quotient  <= w_q_next;
                        remainder <= w_w_next[RW-1:0];
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf2_poly_div_24bit.sv
// ---------------------------------------------------------------------------
// tb_gf2_poly_div_24bit
// Directed and random checks of the carry-less divider. Expected results are
// pushed to a scoreboard when a request is driven and popped when the divider
// raises out_valid. Latency is counted in clock edges after the accepting
// edge: 2N-1-deg(divisor) for a real division, 0 for divide-by-zero.
// ---------------------------------------------------------------------------
module tb_gf2_poly_div_24bit;

    localparam int N  = 24;
    localparam int DW = 2 * N - 1;
    localparam int RW = N - 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [N-1:0]  divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [RW-1:0] remainder;
    logic          div_by_zero;

    typedef struct {
        logic [DW-1:0] q;
        logic [RW-1:0] r;
        logic          dz;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    gf2_poly_div_24bit #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] clmul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [DW-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) begin
            if (b[i]) p = p ^ (DW'(a) << i);
        end
        return p;
    endfunction

    function automatic int degree(input logic [N-1:0] b);
        int d;
        d = 0;
        for (int i = 0; i < N; i++) begin
            if (b[i]) d = i;
        end
        return d;
    endfunction

    // Drive one request, check the result against the scoreboard, optionally
    // hold off out_ready for bp cycles while a stray request is presented.
    task automatic run_txn(input logic [DW-1:0] dvd, input logic [N-1:0] dvs,
                           input logic [DW-1:0] eq, input logic [RW-1:0] er,
                           input logic edz, input int elat, input int bp);
        exp_t e;
        exp_t got;
        int   lat;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.q = eq; e.r = er; e.dz = edz; e.lat = elat;
        sb.push_back(e);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = sb.pop_front();
        chk("out_valid", out_valid, 1);
        chk("latency", lat, got.lat);
        chk("quotient", quotient, got.q);
        chk("remainder", remainder, got.r);
        chk("div_by_zero", div_by_zero, got.dz);
        for (int k = 0; k < bp; k++) begin
            in_valid = 1'b1;
            dividend = ~dvd;
            divisor  = 24'h000001;
            @(posedge clk);
            #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_quotient", quotient, got.q);
            chk("bp_remainder", remainder, got.r);
            chk("bp_dz", div_by_zero, got.dz);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("hs_out_valid", out_valid, 0);
        chk("hs_in_ready", in_ready, 1);
        chk("idle_hold_q", quotient, got.q);
    endtask

    initial begin
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic [N-1:0]  r;
        logic [31:0]   mask;
        int            db;
        int            w;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready_low", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dz", div_by_zero, 0);

        // (x^5+x^4+1) / (x^3+x+1) = x^2+x+1
        run_txn(47'h31, 24'h00000B, 47'h7, 23'h0, 1'b0, 44, 0);
        // (x^46+1) / (x^23+1) = x^23+1, shortest run
        run_txn(47'h4000_0000_0001, 24'h800001, 47'h800001, 23'h0, 1'b0, 24, 0);
        // divide by 1, longest run
        run_txn(47'h5A5A_1234_ABCD, 24'h000001, 47'h5A5A_1234_ABCD, 23'h0, 1'b0, 47, 0);
        // divide by zero
        run_txn(47'h1234, 24'h000000, 47'h0, 23'h0, 1'b1, 0, 0);
        // x^46 / (x+1): all-ones quotient, remainder 1, with backpressure
        run_txn(47'h4000_0000_0000, 24'h000003, 47'h3FFF_FFFF_FFFF, 23'h1, 1'b0, 46, 5);

        // Reset in the 10th RUN cycle discards the request
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 47'h31;
        divisor  = 24'h00000B;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("midrun_busy", in_ready, 0);
        chk("midrun_no_valid", out_valid, 0);
        rst = 1'b1;
        #1;
        chk("midrun_rst_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrun_in_ready", in_ready, 1);
        chk("midrun_out_valid", out_valid, 0);
        chk("midrun_quotient", quotient, 0);
        chk("midrun_remainder", remainder, 0);
        chk("midrun_dz", div_by_zero, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrun_stays_idle", out_valid, 0);
        run_txn(47'h31, 24'h00000B, 47'h7, 23'h0, 1'b0, 44, 0);

        // Random: dividend = a*b (+ r with deg r < deg b) -> quotient a, remainder r
        for (int t = 0; t < 1000; t++) begin
            a    = N'($urandom);
            w    = $urandom_range(1, N);
            mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
            b    = N'($urandom & mask);
            if (b == '0) b = 24'h000001;
            db   = degree(b);
            mask = (32'h1 << db) - 32'h1;
            r    = (t % 2 == 0) ? '0 : N'($urandom & mask);
            run_txn(clmul(a, b) ^ DW'(r), b, DW'(a), RW'(r), 1'b0, DW - db, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
